alt_vipitc131_common_stream_input: RTL and testbench
====================================================

Name: alt_vipitc131_common_stream_input

Overview:
- Receive-side counterpart of the common stream output stage. Sinks an Avalon-ST video stream that uses ready latency 1 on the din side.
- Buffers beats in a small FIFO and presents a ready-latency-0 valid/ready stream on the internal side.
- Gates acceptance with an enable that changes only at image-packet boundaries, so multiple inputs stay frame-aligned.
- Sits at the front of CVI/frame-reader style datapaths.

Parameters:
- DATA_WIDTH, 10, width of din_data/int_data. Must be at least 4, because the packet type is data[3:0].
- FIFO_DEPTH, 4, number of buffered beats. Legal range 2..16. Full throughput requires at least 3.
- LEVEL_WIDTH, derived localparam, equal to ceil(log2(FIFO_DEPTH+1)).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- din_ready  out  1  registered ready; grants one beat in the following cycle
- din_valid  in  1  source beat valid
- din_data  in  DATA_WIDTH  beat data
- din_sop  in  1  start of packet
- din_eop  in  1  end of packet
- int_valid  out  1  internal beat available
- int_ready  in  1  internal consumer accepts (ready latency 0)
- int_data  out  DATA_WIDTH  head-of-FIFO data
- int_sop  out  1  head-of-FIFO sop
- int_eop  out  1  head-of-FIFO eop
- enable  in  1  requested run state
- synced  out  1  1 when the applied enable equals the requested enable
- running  out  1  applied (packet-synchronised) enable
- fill_level  out  LEVEL_WIDTH  FIFO occupancy
- protocol_error  out  1  sticky; din_valid seen without a grant

Behaviour:
- One clock. rst is synchronous and active-high.
- On reset: din_ready=0, ready_d=0, count=0, pointers=0, image_packet=0, between=1, running=0, protocol_error=0.
  - Resulting outputs: int_valid=0, int_data/int_sop/int_eop=0, fill_level=0, synced=~enable.
  - Reset asserted mid-packet discards all buffered beats and in-flight grants.
- ready_d is din_ready delayed one cycle.
- Accept rule: accept = din_valid & ready_d.
- If din_valid=1 and ready_d=0, the beat is ignored and protocol_error is set. It stays set until rst.
- Pop rule: pop = int_valid & int_ready, with int_valid = (count!=0).
- Simultaneous accept and pop leaves count unchanged.
- FIFO storage is not reset. int_data, int_sop and int_eop are forced to 0 whenever int_valid=0.
- Latency: a beat accepted in cycle t appears on int_* in cycle t+1 at the earliest. There is no combinational bypass.
- Ordering is strict FIFO. Pointers wrap modulo FIFO_DEPTH.
- Packet sync, evaluated on accepted beats only:
  - image_packet_nxt = (accept & din_sop & din_data[3:0]==0) | (image_packet & ~(accept & din_eop)).
  - between_nxt = (image_packet & accept & din_eop) | (between & ~(accept & din_sop)).
  - running_nxt = between_nxt ? enable : running.
  - Consequence: control packets (non-zero type) clear between. Enable changes are then deferred until the end of the next image packet.
- din_ready_nxt = running_nxt & (count_nxt + din_ready <= FIFO_DEPTH-1).
  - count_nxt is the occupancy after this cycle's accept and pop.
  - This reserves room for the beat in flight plus the beat granted next cycle, so the FIFO never overflows.
- Disable: din_ready falls one cycle after the accepted eop that ends an image packet.
  - A beat already granted (ready_d=1) is still accepted.
  - The FIFO continues to drain to the int side while disabled.
- synced = (running == enable). fill_level = count.

Test Plan:
- Reset held 3 cycles, then released with enable=1 and no traffic -> running=1 and din_ready=1 after the first edge following release; synced=1; int_valid=0; fill_level=0.
- DEPTH=4, int_ready=1, 8-beat image packet (sop data=0x000, data 1..7, eop on 8th) driven back-to-back -> din_ready stays 1; each beat appears on int_data one cycle after acceptance; int_sop on beat 1, int_eop on beat 8.
- DEPTH=4, int_ready=0, continuous source -> exactly 4 beats accepted; din_ready drops; fill_level=4; then int_ready=1 -> all beats emerge in order, none lost, none duplicated.
- enable 1->0 at beat 3 of an 8-beat image packet -> synced=0 and din_ready stays high through beat 8; din_ready=0 and running=0 the cycle after eop accepted; synced=1 again.
- Control packet (sop data[3:0]=0xF, 3 beats), enable toggled 1->0 during it, then an image packet -> running stays 1 until the image packet's eop is accepted.
- din_valid=1 while ready_d=0 -> beat not written; fill_level unchanged; protocol_error=1 and stays 1 until rst.

Source files
------------

// File: rtl/alt_vipitc131_common_stream_input_if.sv
// Video beat bundle (valid/ready/data/sop/eop) shared by the ready-latency-1
// source side and the ready-latency-0 internal side of the stream input stage.
interface alt_vipitc131_common_stream_input_if #(
  parameter int DATA_WIDTH = 10
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic                  sop;
  logic                  eop;

  modport master (output valid, output data, output sop, output eop, input ready);
  modport slave  (input valid, input data, input sop, input eop, output ready);
endinterface

// File: rtl/alt_vipitc131_common_stream_input.sv
// Stream input stage: ready-latency-1 Avalon-ST sink buffered in a small FIFO and
// re-presented as a ready-latency-0 stream, gated by an image-packet-aligned enable.
module alt_vipitc131_common_stream_input #(
  parameter  int DATA_WIDTH  = 10,
  parameter  int FIFO_DEPTH  = 4,
  localparam int LEVEL_WIDTH = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  alt_vipitc131_common_stream_input_if.slave  din_if,
  alt_vipitc131_common_stream_input_if.master int_if,
  input  logic                   enable_i,
  output logic                   synced_o,
  output logic                   running_o,
  output logic [LEVEL_WIDTH-1:0] fill_level_o,
  output logic                   protocol_error_o
);

  localparam int PTR_WIDTH = $clog2(FIFO_DEPTH);
  localparam int SUM_WIDTH = LEVEL_WIDTH + 1;

  logic [DATA_WIDTH+1:0]  mem_q [FIFO_DEPTH];
  logic [PTR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LEVEL_WIDTH-1:0] count_q, count_d;
  logic                   din_ready_q, din_ready_d;
  logic                   ready_dly_q;
  logic                   image_q, image_d;
  logic                   between_q, between_d;
  logic                   running_q, running_d;
  logic                   proto_err_q, proto_err_d;
  logic                   accept, pop, int_valid;
  logic [SUM_WIDTH-1:0]   room_need;

  function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
    return (p == PTR_WIDTH'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign int_valid = (count_q != '0);
  assign accept    = din_if.valid & ready_dly_q;
  assign pop       = int_valid & int_if.ready;

  always_comb begin
    count_d = count_q;
    if (accept && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!accept && pop) begin
      count_d = count_q - 1'b1;
    end
    wr_ptr_d = accept ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;

    // Enable is only re-sampled while between image packets; control packets
    // clear the between flag, deferring changes to the end of the next image packet.
    image_d   = (accept & din_if.sop & (din_if.data[3:0] == 4'h0)) |
                (image_q & ~(accept & din_if.eop));
    between_d = (image_q & accept & din_if.eop) |
                (between_q & ~(accept & din_if.sop));
    running_d = between_d ? enable_i : running_q;

    // Reserve a slot for the beat granted this cycle as well as the next grant.
    room_need   = SUM_WIDTH'(count_d) + SUM_WIDTH'(din_ready_q);
    din_ready_d = running_d & (room_need <= SUM_WIDTH'(FIFO_DEPTH - 1));

    proto_err_d = proto_err_q | (din_if.valid & ~ready_dly_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      din_ready_q <= 1'b0;
      ready_dly_q <= 1'b0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      image_q     <= 1'b0;
      between_q   <= 1'b1;
      running_q   <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      din_ready_q <= din_ready_d;
      ready_dly_q <= din_ready_q;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      image_q     <= image_d;
      between_q   <= between_d;
      running_q   <= running_d;
      proto_err_q <= proto_err_d;
    end
  end

  // Storage carries no reset; the output mux hides stale contents.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      mem_q[wr_ptr_q] <= {din_if.sop, din_if.eop, din_if.data};
    end
  end

  assign din_if.ready = din_ready_q;
  assign int_if.valid = int_valid;
  assign {int_if.sop, int_if.eop, int_if.data} = int_valid ? mem_q[rd_ptr_q] : '0;

  assign synced_o         = (running_q == enable_i);
  assign running_o        = running_q;
  assign fill_level_o     = count_q;
  assign protocol_error_o = proto_err_q;

endmodule

// File: tb/tb_alt_vipitc131_common_stream_input.sv
// Directed bench for the stream input stage; accepted beats are queued on drive
// and popped against the internal side whenever a beat is consumed.
module tb_alt_vipitc131_common_stream_input;
  localparam int DW    = 10;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b1;
  logic          synced, running, protocol_error;
  logic [LW-1:0] fill_level;
  logic          tb_grant = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  int n_sent;
  logic [DW+1:0] sb[$];
  logic [DW+1:0] exp_beat;

  alt_vipitc131_common_stream_input_if #(.DATA_WIDTH(DW)) din_bus ();
  alt_vipitc131_common_stream_input_if #(.DATA_WIDTH(DW)) int_bus ();

  alt_vipitc131_common_stream_input #(
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .din_if           (din_bus),
    .int_if           (int_bus),
    .enable_i         (enable),
    .synced_o         (synced),
    .running_o        (running),
    .fill_level_o     (fill_level),
    .protocol_error_o (protocol_error)
  );

  always #5 clk = ~clk;

  // Source-side view of the grant: din_ready as it was in the previous cycle.
  always @(posedge clk) tb_grant <= din_bus.ready;

  always @(negedge clk) begin
    if (!rst && int_bus.valid === 1'b1 && int_bus.ready === 1'b1) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $error("FAIL sb_underflow: observed beat %0h expected no beat", int_bus.data);
      end else begin
        exp_beat = sb.pop_front();
        assert ({int_bus.sop, int_bus.eop, int_bus.data} === exp_beat) else begin
          n_err++;
          $error("FAIL sb_beat: observed %0h expected %0h",
                 {int_bus.sop, int_bus.eop, int_bus.data}, exp_beat);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic s, input logic e);
    int guard = 0;
    while (!tb_grant && guard < 50) begin
      din_bus.valid = 1'b0;
      tick();
      guard++;
    end
    if (!tb_grant) begin
      n_cmp++;
      n_err++;
      $error("FAIL grant_timeout: observed no grant expected grant");
      din_bus.valid = 1'b0;
      return;
    end
    din_bus.valid = 1'b1;
    din_bus.data  = d;
    din_bus.sop   = s;
    din_bus.eop   = e;
    sb.push_back({s, e, d});
    tick();
  endtask

  task automatic idle(input int n);
    din_bus.valid = 1'b0;
    din_bus.sop   = 1'b0;
    din_bus.eop   = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    din_bus.valid = 1'b0;
    din_bus.data  = '0;
    din_bus.sop   = 1'b0;
    din_bus.eop   = 1'b0;
    int_bus.ready = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_din_ready", din_bus.ready, 0);
    check("rst_int_valid", int_bus.valid, 0);
    check("rst_int_data", int_bus.data, 0);
    check("rst_fill", fill_level, 0);
    check("rst_running", running, 0);
    check("rst_synced", synced, 0);
    check("rst_proto_err", protocol_error, 0);
    rst = 1'b0;
    tick();
    check("rel_running", running, 1);
    check("rel_din_ready", din_bus.ready, 1);
    check("rel_synced", synced, 1);
    check("rel_int_valid", int_bus.valid, 0);
    check("rel_fill", fill_level, 0);

    // Back-to-back image packet with consumer always ready
    int_bus.ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send_beat(DW'(i), i == 0, i == 7);
      check("b2b_int_valid", int_bus.valid, 1);
      check("b2b_int_data", int_bus.data, i);
      check("b2b_int_sop", int_bus.sop, (i == 0));
      check("b2b_int_eop", int_bus.eop, (i == 7));
      check("b2b_din_ready", din_bus.ready, 1);
    end
    idle(3);
    check("b2b_drained", sb.size(), 0);
    check("b2b_fill", fill_level, 0);

    // Stalled consumer: the FIFO fills to depth and back-pressures
    int_bus.ready = 1'b0;
    n_sent = 0;
    for (int i = 0; i < 12; i++) begin
      if (tb_grant) begin
        din_bus.valid = 1'b1;
        din_bus.data  = DW'(10'h100 + n_sent);
        din_bus.sop   = (n_sent == 0);
        din_bus.eop   = 1'b0;
        sb.push_back({din_bus.sop, 1'b0, din_bus.data});
        n_sent++;
      end else begin
        din_bus.valid = 1'b0;
      end
      tick();
    end
    din_bus.valid = 1'b0;
    check("full_accepted", n_sent, 4);
    check("full_fill", fill_level, 4);
    check("full_din_ready", din_bus.ready, 0);
    check("full_head_data", int_bus.data, 10'h100);
    int_bus.ready = 1'b1;
    idle(6);
    check("full_drained", sb.size(), 0);
    check("full_fill_after", fill_level, 0);
    check("full_int_valid", int_bus.valid, 0);
    check("full_int_data_gated", int_bus.data, 0);
    send_beat(10'h1FF, 1'b0, 1'b1);
    idle(2);

    // Disable requested mid image packet takes effect after its eop
    for (int i = 0; i < 8; i++) begin
      if (i == 2) enable = 1'b0;
      send_beat(DW'(10'h040 + i) & 10'h3F0, i == 0, i == 7);
      if (i == 2) begin
        check("dis_synced_low", synced, 0);
        check("dis_running_hold", running, 1);
      end
      if (i < 7) check("dis_din_ready_hi", din_bus.ready, 1);
    end
    check("dis_din_ready_lo", din_bus.ready, 0);
    check("dis_running_lo", running, 0);
    check("dis_synced_again", synced, 1);
    idle(3);
    check("dis_drained", int_bus.valid, 0);
    check("dis_still_off", din_bus.ready, 0);

    // Control packet defers the enable change to the next image packet's eop
    enable = 1'b1;
    tick();
    check("ctl_running_on", running, 1);
    check("ctl_din_ready_on", din_bus.ready, 1);
    send_beat(10'h00F, 1'b1, 1'b0);
    enable = 1'b0;
    send_beat(10'h001, 1'b0, 1'b0);
    send_beat(10'h002, 1'b0, 1'b1);
    check("ctl_running_after_ctl", running, 1);
    send_beat(10'h000, 1'b1, 1'b0);
    send_beat(10'h005, 1'b0, 1'b0);
    check("ctl_running_in_img", running, 1);
    check("ctl_din_ready_in_img", din_bus.ready, 1);
    send_beat(10'h006, 1'b0, 1'b1);
    check("ctl_running_off", running, 0);
    check("ctl_din_ready_off", din_bus.ready, 0);
    check("ctl_synced", synced, 1);
    idle(3);
    check("ctl_drained", sb.size(), 0);

    // Ungranted beat is dropped and latches the sticky error
    check("perr_before", protocol_error, 0);
    din_bus.valid = 1'b1;
    din_bus.data  = 10'h3AA;
    din_bus.sop   = 1'b1;
    din_bus.eop   = 1'b1;
    tick();
    din_bus.valid = 1'b0;
    check("perr_fill", fill_level, 0);
    check("perr_int_valid", int_bus.valid, 0);
    check("perr_set", protocol_error, 1);
    idle(5);
    check("perr_sticky", protocol_error, 1);

    // Reset mid-packet discards buffered beats and clears the error
    enable = 1'b1;
    tick();
    int_bus.ready = 1'b0;
    send_beat(10'h000, 1'b1, 1'b0);
    send_beat(10'h007, 1'b0, 1'b0);
    din_bus.valid = 1'b0;
    check("mid_fill", fill_level, 2);
    rst = 1'b1;
    tick();
    sb.delete();
    check("mid_rst_fill", fill_level, 0);
    check("mid_rst_int_valid", int_bus.valid, 0);
    check("mid_rst_int_data", int_bus.data, 0);
    check("mid_rst_din_ready", din_bus.ready, 0);
    check("mid_rst_perr", protocol_error, 0);
    check("mid_rst_synced", synced, 0);
    rst = 1'b0;
    tick();
    check("mid_rel_running", running, 1);
    check("mid_rel_din_ready", din_bus.ready, 1);
    int_bus.ready = 1'b1;
    send_beat(10'h000, 1'b1, 1'b0);
    send_beat(10'h02A, 1'b0, 1'b1);
    idle(3);
    check("mid_rel_drained", sb.size(), 0);
    check("mid_rel_fill", fill_level, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
